// File: rtl/difftest_pkg.sv
// Shared types and width helpers for the difftest commit path.
package difftest_pkg;

  // Default datapath width used by the packed layouts below.
  localparam int DIFFTEST_XLEN = 32;

  // One buffered commit entry. pc sits in the low bits, then inst, then skip.
  // The flat vectors inside the queue use the same ordering for any XLEN.
  typedef struct packed {
    logic                     skip;
    logic [DIFFTEST_XLEN-1:0] inst;
    logic [DIFFTEST_XLEN-1:0] pc;
  } difftest_entry_t;

  // Layout consumed by the downstream Difftest packing logic.
  typedef struct packed {
    logic                     valid;
    logic                     skip;
    logic [7:0]               coreid;
    logic [7:0]               index;
    logic [DIFFTEST_XLEN-1:0] inst;
    logic [63:0]              pc;
  } difftest_info_t;

  // Index width for a power-of-two storage array (never zero).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Flat entry width: pc + inst + skip.
  function automatic int entry_width(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/difftest_lane_compactor.sv
// Packs the committing lanes of one retire group into consecutive slots,
// lowest lane first, and reports how many slots were filled.
module difftest_lane_compactor
  import difftest_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int XLEN   = 32
) (
  input  logic [NUM_IN*XLEN-1:0]                 lane_pc_i,
  input  logic [NUM_IN*XLEN-1:0]                 lane_inst_i,
  input  logic [NUM_IN-1:0]                      lane_skip_i,
  input  logic [NUM_IN-1:0]                      commit_i,
  output logic [NUM_IN*entry_width(XLEN)-1:0]    entries_o,
  output logic [cnt_width(NUM_IN)-1:0]           push_cnt_o
);

  localparam int EW     = entry_width(XLEN);
  localparam int PUSH_W = cnt_width(NUM_IN);

  // prefix[i] = number of committing lanes below lane i = its output slot.
  logic [PUSH_W-1:0] prefix [NUM_IN];

  // Prefix popcount across the commit mask.
  always_comb begin
    prefix[0] = '0;
    for (int i = 1; i < NUM_IN; i++) begin
      prefix[i] = prefix[i-1] + PUSH_W'(commit_i[i-1]);
    end
  end

  assign push_cnt_o = prefix[NUM_IN-1] + PUSH_W'(commit_i[NUM_IN-1]);

  // Scatter each committing lane into the slot given by its prefix count.
  always_comb begin
    entries_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (commit_i[i]) begin
        entries_o[int'(prefix[i])*EW +: EW] = {lane_skip_i[i],
                                               lane_inst_i[i*XLEN +: XLEN],
                                               lane_pc_i[i*XLEN +: XLEN]};
      end
    end
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Commit queue between the retire stage and the Difftest model: compacts
// committing lanes, buffers them in a circular FIFO and drains up to NUM_OUT
// per cycle. Also tracks overflow, retired count and a commit-hang watchdog.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2,
  parameter int DEPTH       = 16,
  parameter int XLEN        = 32,
  parameter int HANG_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN*XLEN-1:0]    in_pc,
  input  logic [NUM_IN*XLEN-1:0]    in_inst,
  input  logic [NUM_IN-1:0]         in_commit,
  input  logic [NUM_IN-1:0]         in_skip,
  output logic                      in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*XLEN-1:0]   out_pc,
  output logic [NUM_OUT*XLEN-1:0]   out_inst,
  output logic [NUM_OUT-1:0]        out_skip,
  input  logic                      out_ready,
  output logic                      overflow,
  output logic                      hang,
  output logic [63:0]               retired_cnt
);

  localparam int EW     = entry_width(XLEN);
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int PUSH_W = cnt_width(NUM_IN);
  localparam int IDLE_W = cnt_width(HANG_CYCLES);

  logic [EW-1:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [63:0]            retired_q, retired_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   overflow_q, overflow_d;
  logic                   hang_q, hang_d;

  logic                   any_commit;
  logic [NUM_IN-1:0]      push_mask;
  logic [NUM_IN*EW-1:0]   push_entries;
  logic [PUSH_W-1:0]      push_cnt;
  logic [CNT_W-1:0]       pop_cnt;

  // Space check uses only the registered count so in_ready never sees out_ready.
  assign in_ready   = (int'(count_q) <= (DEPTH - NUM_IN));
  assign any_commit = |in_commit;
  assign push_mask  = in_commit & {NUM_IN{in_ready}};

  difftest_lane_compactor #(
    .NUM_IN (NUM_IN),
    .XLEN   (XLEN)
  ) u_compactor (
    .lane_pc_i   (in_pc),
    .lane_inst_i (in_inst),
    .lane_skip_i (in_skip),
    .commit_i    (push_mask),
    .entries_o   (push_entries),
    .push_cnt_o  (push_cnt)
  );

  // Number of entries the consumer takes this cycle.
  always_comb begin
    pop_cnt = '0;
    if (out_ready) begin
      pop_cnt = (count_q > CNT_W'(NUM_OUT)) ? CNT_W'(NUM_OUT) : count_q;
    end
  end

  // Next-state for pointers, occupancy, counters and sticky flags.
  always_comb begin
    count_d    = count_q + CNT_W'(push_cnt) - pop_cnt;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_cnt);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_cnt);
    retired_d  = retired_q + 64'(push_cnt);
    overflow_d = overflow_q | (any_commit & ~in_ready);
    idle_d     = idle_q;
    if (any_commit) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(HANG_CYCLES)) begin
      idle_d = idle_q + 1'b1;
    end
    hang_d = hang_q | (idle_d == IDLE_W'(HANG_CYCLES));
  end

  // Control state; async reset discards every buffered entry at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      retired_q  <= '0;
      idle_q     <= '0;
      overflow_q <= 1'b0;
      hang_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      retired_q  <= retired_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
      hang_q     <= hang_d;
    end
  end

  // Entry storage: write the compacted slots starting at wr_ptr, wrapping.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_IN; j++) begin
      if (j < int'(push_cnt)) begin
        mem_q[wr_ptr_q + PTR_W'(j)] <= push_entries[j*EW +: EW];
      end
    end
  end

  // Output lane k shows the entry k places behind the read pointer.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    logic [PTR_W-1:0] rd_idx;
    logic [EW-1:0]    ent;
    assign rd_idx        = rd_ptr_q + PTR_W'(gi);
    assign out_valid[gi] = (count_q > CNT_W'(gi));
    assign ent           = out_valid[gi] ? mem_q[rd_idx] : '0;
    assign out_pc[gi*XLEN +: XLEN]   = ent[XLEN-1:0];
    assign out_inst[gi*XLEN +: XLEN] = ent[2*XLEN-1:XLEN];
    assign out_skip[gi]              = ent[2*XLEN];
  end

  assign overflow    = overflow_q;
  assign hang        = hang_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Scoreboard bench for difftest_commit_queue: a queue-based reference model
// tracks expected contents; a negedge monitor compares every output.
module tb_difftest_commit_queue;

  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 2;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 32;
  localparam int HANG    = 4096;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_IN*XLEN-1:0]  in_pc;
  logic [NUM_IN*XLEN-1:0]  in_inst;
  logic [NUM_IN-1:0]       in_commit;
  logic [NUM_IN-1:0]       in_skip;
  logic                    in_ready;
  logic [NUM_OUT-1:0]      out_valid;
  logic [NUM_OUT*XLEN-1:0] out_pc;
  logic [NUM_OUT*XLEN-1:0] out_inst;
  logic [NUM_OUT-1:0]      out_skip;
  logic                    out_ready;
  logic                    overflow;
  logic                    hang;
  logic [63:0]             retired_cnt;

  difftest_commit_queue #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH), .XLEN(XLEN), .HANG_CYCLES(HANG)
  ) dut (
    .clock(clock), .reset(reset), .in_pc(in_pc), .in_inst(in_inst),
    .in_commit(in_commit), .in_skip(in_skip), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_skip(out_skip),
    .out_ready(out_ready), .overflow(overflow), .hang(hang), .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        skip;
  } ent_t;

  // Reference model state
  ent_t            mq[$];
  int              m_idle = 0;
  bit              m_hang = 0;
  bit              m_ovf  = 0;
  longint unsigned m_ret  = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of expected entries, updated at each clock edge.
  initial begin : model
    int  npop;
    bit  rdy;
    ent_t e;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq.delete();
        m_idle = 0; m_hang = 0; m_ovf = 0; m_ret = 0;
      end else begin
        rdy  = (DEPTH - mq.size()) >= NUM_IN;
        npop = out_ready ? ((mq.size() < NUM_OUT) ? mq.size() : NUM_OUT) : 0;
        repeat (npop) void'(mq.pop_front());
        if (in_commit != 0 && !rdy) m_ovf = 1;
        if (rdy) begin
          for (int i = 0; i < NUM_IN; i++) begin
            if (in_commit[i]) begin
              e.pc   = in_pc[i*XLEN +: XLEN];
              e.inst = in_inst[i*XLEN +: XLEN];
              e.skip = in_skip[i];
              mq.push_back(e);
              m_ret++;
            end
          end
        end
        if (in_commit != 0) m_idle = 0;
        else if (m_idle < HANG) m_idle++;
        if (m_idle == HANG) m_hang = 1;
      end
    end
  end

  // Monitor: compare every output against the model on the falling edge.
  initial begin : monitor
    ent_t e;
    bit   v;
    forever begin
      @(negedge clock);
      for (int k = 0; k < NUM_OUT; k++) begin
        v = (mq.size() > k);
        e = v ? mq[k] : '0;
        chk($sformatf("lane%0d_valid", k), 64'(out_valid[k]), 64'(v));
        chk($sformatf("lane%0d_pc", k), 64'(out_pc[k*XLEN +: XLEN]), 64'(e.pc));
        chk($sformatf("lane%0d_inst", k), 64'(out_inst[k*XLEN +: XLEN]), 64'(e.inst));
        chk($sformatf("lane%0d_skip", k), 64'(out_skip[k]), 64'(e.skip));
      end
      chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= NUM_IN));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("hang", 64'(hang), 64'(m_hang));
      chk("retired_cnt", retired_cnt, m_ret);
    end
  end

  // Apply one cycle of stimulus, then return 1 time unit after the edge.
  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic r,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    in_commit = c;
    in_skip   = s;
    out_ready = r;
    in_pc     = {pc1, pc0};
    in_inst   = {32'($urandom), 32'($urandom)};
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rpc();
    return 32'($urandom) & 32'hFFFF_FFFC;
  endfunction

  initial begin : stim
    reset = 1'b0;
    in_commit = '0; in_skip = '0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_retired", retired_cnt, 64'd0);

    // Watchdog boundary: hang asserts exactly on the HANG-th idle edge.
    repeat (HANG - 1) drive(2'b00, 2'b00, 1'b1, 32'h0, 32'h0);
    chk("hang_before_limit", 64'(hang), 64'd0);
    drive(2'b00, 2'b00, 1'b1, 32'h0, 32'h0);
    chk("hang_at_limit", 64'(hang), 64'd1);

    // Gap in the commit mask: only lane 1 enqueues, at out lane 0.
    drive(2'b10, 2'b00, 1'b0, 32'h1111_0000, 32'h8000_0004);
    chk("gap_out_valid", 64'(out_valid), 64'b01);
    chk("gap_out_pc0", 64'(out_pc[31:0]), 64'h8000_0004);
    chk("gap_retired", retired_cnt, 64'd1);
    chk("hang_sticky", 64'(hang), 64'd1);

    // Drain, then fill to full with the consumer stalled.
    repeat (3) drive(2'b00, 2'b00, 1'b1, 32'h0, 32'h0);
    repeat (8) drive(2'b11, 2'b00, 1'b0, rpc(), rpc());
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_overflow_clear", 64'(overflow), 64'd0);
    drive(2'b11, 2'b00, 1'b0, rpc(), rpc());
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("full_retired", retired_cnt, 64'd17);

    // Sustained push/pop across pointer wrap.
    repeat (20) drive(2'b11, 2'b00, 1'b1, rpc(), rpc());
    drive(2'b11, 2'b01, 1'b1, rpc(), rpc());
    repeat (8) drive(2'b00, 2'b00, 1'b1, 32'h0, 32'h0);

    // Random traffic.
    repeat (400) drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) != 0), rpc(), rpc());

    // Asynchronous reset with nine entries buffered.
    repeat (10) drive(2'b00, 2'b00, 1'b1, 32'h0, 32'h0);
    repeat (4) drive(2'b11, 2'b00, 1'b0, rpc(), rpc());
    drive(2'b01, 2'b00, 1'b0, rpc(), rpc());
    chk("pre_reset_valid", 64'(out_valid), 64'b11);
    in_commit = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_retired", retired_cnt, 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    chk("async_rst_hang", 64'(hang), 64'd0);
    chk("async_rst_pc0", 64'(out_pc[31:0]), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_retired", retired_cnt, 64'd0);

    repeat (150) drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 1) != 0), rpc(), rpc());
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
